// File: rtl/drink_selector_fsm.sv
// drink_selector_fsm
//   Product/option selector between the debounced front panel and the
//   dispenser/display drivers. A single product request opens an option
//   window (OPTS); confirm runs a timed dispense whose length grows with the
//   number of active options; the FSM then pulses done and returns to idle.
//   Inactivity in OPTS auto-cancels with a timeout pulse.
//
// Ports
//   clk         system clock, rising edge
//   areset_n    asynchronous active-low reset
//   item_req    product buttons, one bit per product (synchronised)
//   opt_toggle  one-cycle pulses, each flips the matching option bit
//   confirm     start dispense
//   cancel      abort selection
//   state       IDLE=0, OPTS=1, DISPENSE=2, DONE=3
//   sel_item    index of the latched product
//   sel_valid   high in OPTS and DISPENSE
//   opt_sel     latched option bits
//   dispense    high for every DISPENSE cycle
//   done        one-cycle pulse in DONE
//   err         one-cycle pulse on a multi-product request
//   timeout     one-cycle pulse on inactivity abort
module drink_selector_fsm #(
    parameter int unsigned N_ITEMS        = 4,
    parameter int unsigned N_OPTS         = 2,
    parameter int unsigned BASE_CYCLES    = 8,
    parameter int unsigned EXTRA_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    localparam int unsigned ITEM_W        = $clog2(N_ITEMS)
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic [N_ITEMS-1:0] item_req,
    input  logic [N_OPTS-1:0] opt_toggle,
    input  logic              confirm,
    input  logic              cancel,
    output logic [1:0]        state,
    output logic [ITEM_W-1:0] sel_item,
    output logic              sel_valid,
    output logic [N_OPTS-1:0] opt_sel,
    output logic              dispense,
    output logic              done,
    output logic              err,
    output logic              timeout
);

    localparam int unsigned D_MAX   = BASE_CYCLES + EXTRA_CYCLES * N_OPTS;
    localparam int unsigned CNT_MAX = (D_MAX > TIMEOUT_CYCLES) ? D_MAX : TIMEOUT_CYCLES;
    // Counter holds "remaining cycles minus one", so CNT_MAX-1 is the largest value.
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPTS     = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_r, state_n;
    logic [ITEM_W-1:0] sel_item_n;
    logic [N_OPTS-1:0] opt_sel_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic              err_n, timeout_n;

    int unsigned       req_n;
    int unsigned       opt_n;
    logic [ITEM_W-1:0] req_idx;
    logic              req_one, req_multi;
    logic [CNT_W-1:0]  d_load;

    // Request decode: number of pressed buttons and index of the highest one.
    always_comb begin
        req_n   = 0;
        req_idx = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (item_req[i]) begin
                req_n   = req_n + 1;
                req_idx = ITEM_W'(i);
            end
        end
        req_one   = (req_n == 1);
        req_multi = (req_n > 1);
    end

    // Dispense length from the options latched before this cycle.
    always_comb begin
        opt_n = 0;
        for (int unsigned i = 0; i < N_OPTS; i++) begin
            if (opt_sel[i]) opt_n = opt_n + 1;
        end
        d_load = CNT_W'(BASE_CYCLES + EXTRA_CYCLES * opt_n - 1);
    end

    always_comb begin
        state_n    = state_r;
        sel_item_n = sel_item;
        opt_sel_n  = opt_sel;
        cnt_n      = cnt_r;
        err_n      = 1'b0;
        timeout_n  = 1'b0;
        unique case (state_r)
            IDLE: begin
                if (req_one) begin
                    state_n    = OPTS;
                    sel_item_n = req_idx;
                    opt_sel_n  = '0;
                    cnt_n      = TO_LOAD;
                end else if (req_multi) begin
                    err_n = 1'b1;
                end
            end
            OPTS: begin
                // Events are exclusive: only the highest-priority one acts.
                if (cancel) begin
                    state_n    = IDLE;
                    sel_item_n = '0;
                    opt_sel_n  = '0;
                    cnt_n      = '0;
                end else if (confirm) begin
                    state_n = DISPENSE;
                    cnt_n   = d_load;
                end else if (req_one && (req_idx != sel_item)) begin
                    sel_item_n = req_idx;
                    cnt_n      = TO_LOAD;
                end else if (req_multi) begin
                    err_n = 1'b1;
                    cnt_n = TO_LOAD;
                end else if (|opt_toggle) begin
                    opt_sel_n = opt_sel ^ opt_toggle;
                    cnt_n     = TO_LOAD;
                end else if (cnt_r == '0) begin
                    state_n    = IDLE;
                    timeout_n  = 1'b1;
                    sel_item_n = '0;
                    opt_sel_n  = '0;
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                end
            end
            DISPENSE: begin
                if (cnt_r == '0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                state_n    = IDLE;
                sel_item_n = '0;
                opt_sel_n  = '0;
                cnt_n      = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_r   <= IDLE;
            sel_item  <= '0;
            opt_sel   <= '0;
            cnt_r     <= '0;
            sel_valid <= 1'b0;
            dispense  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_r   <= state_n;
            sel_item  <= sel_item_n;
            opt_sel   <= opt_sel_n;
            cnt_r     <= cnt_n;
            sel_valid <= (state_n == OPTS) || (state_n == DISPENSE);
            dispense  <= (state_n == DISPENSE);
            done      <= (state_n == DONE);
            err       <= err_n;
            timeout   <= timeout_n;
        end
    end

    assign state = state_r;

endmodule
